// File: rtl/waveform_pkg.sv
// waveform_pkg
// Shared types and helpers for the waveform analyzer.
//   xstate_t  : crossing-detector FSM states (WAIT_LOW, WAIT_HIGH)
//   threshold : hysteresis threshold calculation (MIDLINE +/- HYST)
package waveform_pkg;

    typedef enum logic {
        WAIT_LOW  = 1'b0,
        WAIT_HIGH = 1'b1
    } xstate_t;

    // Upper threshold when upper=1, lower threshold otherwise.
    // Computed in 32-bit arithmetic; callers slice to SAMPLE_W+1 bits.
    function automatic int unsigned threshold(input int unsigned midline,
                                              input int unsigned hyst,
                                              input bit          upper);
        return upper ? (midline + hyst) : (midline - hyst);
    endfunction

endpackage

// File: rtl/waveform_analyzer_crossing_detector.sv
// crossing_detector
// Hysteresis comparator plus two-state FSM that flags rising midline
// crossings. The FSM only advances on accepted samples.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sample_valid  : qualifies sample (no ready; every valid sample is consumed
//                   in the cycle it is presented)
//   sample        : unsigned input sample
//   clear         : forces the FSM back to WAIT_LOW on the current accepted
//                   sample (used when a measurement window times out)
//   crossing      : combinational strobe, high for the accepted sample that
//                   completes a low-then-high excursion
module crossing_detector
    import waveform_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 9,
    parameter int unsigned MIDLINE  = 128,
    parameter int unsigned HYST     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                clear,
    output logic                crossing
);

    localparam int unsigned   HI_I = threshold(MIDLINE, HYST, 1'b1);
    localparam int unsigned   LO_I = threshold(MIDLINE, HYST, 1'b0);
    localparam logic [SAMPLE_W:0] HI = HI_I[SAMPLE_W:0];
    localparam logic [SAMPLE_W:0] LO = LO_I[SAMPLE_W:0];

    xstate_t         state, state_next;
    logic [SAMPLE_W:0] sample_ext;
    logic            is_low;
    logic            is_high;

    // One extra bit so HI = MIDLINE+HYST can never wrap in the compare.
    assign sample_ext = {1'b0, sample};
    assign is_low     = (sample_ext <= LO);
    assign is_high    = (sample_ext >= HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        crossing   = 1'b0;
        if (sample_valid) begin
            case (state)
                WAIT_LOW: begin
                    if (is_low) begin
                        state_next = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (is_high) begin
                        crossing   = 1'b1;
                        state_next = WAIT_LOW;
                    end
                end
                default: state_next = WAIT_LOW;
            endcase
            // A timeout restarts the search from the low side.
            if (clear) begin
                state_next = WAIT_LOW;
            end
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// waveform_analyzer
// Measures period (in accepted samples) and per-cycle min/max of an unsigned
// sample stream, using rising midline crossings with hysteresis.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sample_valid  : qualifies sample; one sample accepted per high cycle,
//                   no backpressure
//   sample        : unsigned sample
//   meas_valid    : one-cycle pulse, new period/amp_max/amp_min
//   period        : accepted samples in the last full cycle
//   amp_max       : largest sample in the last full cycle
//   amp_min       : smallest sample in the last full cycle
//   locked        : set by the first measurement, cleared by timeout/reset
//   timeout       : one-cycle pulse, window counter ran out without a crossing
module waveform_analyzer
    import waveform_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 9,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned MIDLINE  = 128,
    parameter int unsigned HYST     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                meas_valid,
    output logic [PERIOD_W-1:0] period,
    output logic [SAMPLE_W-1:0] amp_max,
    output logic [SAMPLE_W-1:0] amp_min,
    output logic                locked,
    output logic                timeout
);

    // Last count value before period would overflow: 2**PERIOD_W-2.
    localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

    logic                crossing;
    logic                first_seen;
    logic [PERIOD_W-1:0] cnt;
    logic [SAMPLE_W-1:0] trk_max;
    logic [SAMPLE_W-1:0] trk_min;
    logic                expire;

    // A non-crossing sample at CNT_LAST ends the window; a crossing at the
    // same count is still a legal measurement of 2**PERIOD_W-1 samples.
    assign expire = sample_valid && !crossing && first_seen && (cnt == CNT_LAST);

    crossing_detector #(
        .SAMPLE_W (SAMPLE_W),
        .MIDLINE  (MIDLINE),
        .HYST     (HYST)
    ) u_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear        (expire),
        .crossing     (crossing)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_seen <= 1'b0;
            cnt        <= '0;
            trk_max    <= '0;
            trk_min    <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
            period     <= '0;
            amp_max    <= '0;
            amp_min    <= '0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sample_valid) begin
                if (crossing) begin
                    // The opening crossing only starts a window; every later
                    // crossing closes one and reports it.
                    if (first_seen) begin
                        period     <= cnt + 1'b1;
                        amp_max    <= trk_max;
                        amp_min    <= trk_min;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                    end
                    first_seen <= 1'b1;
                    cnt        <= '0;
                    trk_max    <= sample;
                    trk_min    <= sample;
                end else if (first_seen) begin
                    if (expire) begin
                        timeout    <= 1'b1;
                        locked     <= 1'b0;
                        first_seen <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (sample > trk_max) begin
                            trk_max <= sample;
                        end
                        if (sample < trk_min) begin
                            trk_min <= sample;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_analyzer.sv
module tb_waveform_analyzer;

  localparam int SW = 9;
  localparam int PW = 8;
  localparam int MID = 128;
  localparam int HY = 8;
  localparam int HI = MID + HY;
  localparam int LO = MID - HY;
  localparam real PI = 3.14159265358979;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          meas_valid;
  logic [PW-1:0] period;
  logic [SW-1:0] amp_max;
  logic [SW-1:0] amp_min;
  logic          locked;
  logic          timeout;

  waveform_analyzer #(
    .SAMPLE_W (SW),
    .PERIOD_W (PW),
    .MIDLINE  (MID),
    .HYST     (HY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .meas_valid   (meas_valid),
    .period       (period),
    .amp_max      (amp_max),
    .amp_min      (amp_min),
    .locked       (locked),
    .timeout      (timeout)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_meas = 0;
  int n_to = 0;
  int last_meas = 0;
  int meas_gap = 0;
  logic [SW-1:0] sine_tab [32];
  int sine_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the samples of the open window in a queue; period is its length
  // and the extremes are found by scanning it when the window closes.
  bit m_armed = 0;
  bit m_first = 0;
  int win_q[$];
  logic [PW+2*SW-1:0] exp_q[$];
  logic          e_meas = 0;
  logic          e_timeout = 0;
  logic          e_locked = 0;
  logic [PW-1:0] e_period = '0;
  logic [SW-1:0] e_max = '0;
  logic [SW-1:0] e_min = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed = 0; m_first = 0; win_q.delete();
      e_meas = 0; e_timeout = 0; e_locked = 0;
      e_period = '0; e_max = '0; e_min = '0;
    end else begin
      e_meas = 0;
      e_timeout = 0;
      if (sample_valid) begin
        if (m_armed && int'(sample) >= HI) begin
          if (m_first) begin
            int mx, mn;
            mx = 0; mn = 1 << SW;
            foreach (win_q[k]) begin
              if (win_q[k] > mx) mx = win_q[k];
              if (win_q[k] < mn) mn = win_q[k];
            end
            e_period = PW'(win_q.size());
            e_max = SW'(mx);
            e_min = SW'(mn);
            e_meas = 1;
            e_locked = 1;
            exp_q.push_back({e_period, e_max, e_min});
          end
          win_q.delete();
          win_q.push_back(int'(sample));
          m_first = 1;
          m_armed = 0;
        end else begin
          if (!m_armed && int'(sample) <= LO) m_armed = 1;
          if (m_first) begin
            if (win_q.size() == (1 << PW) - 1) begin
              e_timeout = 1; e_locked = 0; m_first = 0; m_armed = 0;
              win_q.delete();
            end else begin
              win_q.push_back(int'(sample));
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      check("meas_valid", int'(meas_valid), int'(e_meas));
      check("timeout", int'(timeout), int'(e_timeout));
      check("locked", int'(locked), int'(e_locked));
      check("period", int'(period), int'(e_period));
      check("amp_max", int'(amp_max), int'(e_max));
      check("amp_min", int'(amp_min), int'(e_min));
      if (meas_valid && timeout) check("meas_and_timeout", 1, 0);
      if (meas_valid) begin
        n_meas++;
        meas_gap = cyc - last_meas;
        last_meas = cyc;
        if (exp_q.size() == 0) begin
          check("meas_unexpected", 1, 0);
        end else begin
          logic [PW+2*SW-1:0] e;
          e = exp_q.pop_front();
          check("sb_meas", int'({period, amp_max, amp_min}), int'(e));
        end
      end
      if (timeout) n_to++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic v, input int s);
    sample_valid = v;
    sample = SW'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 0);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic square(input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < 5; i++) put(1'b1, 100);
      for (int i = 0; i < 5; i++) put(1'b1, 160);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_m, base_t;
    for (int i = 0; i < 32; i++)
      sine_tab[i] = SW'(int'(127.5 + 127.5 * $sin(2.0 * PI * i / 32.0)));

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_period", int'(period), 0);
    check("rst_amp_max", int'(amp_max), 0);
    check("rst_amp_min", int'(amp_min), 0);
    rst_n = 1'b1;
    idle(2);

    // Sine, continuous valid: opening crossing at index 33, closings every 32.
    for (int i = 0; i < 192; i++) begin
      put(1'b1, int'(sine_tab[sine_idx % 32]));
      sine_idx++;
    end
    idle(1);
    check("sine_n_meas", n_meas, 4);
    check("sine_gap", meas_gap, 32);
    check("sine_period", int'(period), 32);
    check("sine_amp_max", int'(amp_max), 255);
    check("sine_amp_min", int'(amp_min), 0);
    check("sine_locked", int'(locked), 1);

    // Same source, valid one cycle in three.
    base_m = n_meas;
    for (int i = 0; i < 128; i++) begin
      put(1'b1, int'(sine_tab[sine_idx % 32]));
      sine_idx++;
      put(1'b0, 0);
      put(1'b0, 0);
    end
    idle(1);
    check("sine3_n_meas", n_meas - base_m, 4);
    check("sine3_gap", meas_gap, 96);
    check("sine3_period", int'(period), 32);

    // Square 100/160, 5 samples each level.
    do_reset();
    base_m = n_meas;
    square(4);
    idle(1);
    check("sq_n_meas", n_meas - base_m, 3);
    check("sq_period", int'(period), 10);
    check("sq_amp_max", int'(amp_max), 160);
    check("sq_amp_min", int'(amp_min), 100);

    // In-band 125/131 never produces an event.
    do_reset();
    base_m = n_meas; base_t = n_to;
    for (int i = 0; i < 300; i++) put(1'b1, (i % 2) ? 131 : 125);
    idle(1);
    check("band_n_meas", n_meas - base_m, 0);
    check("band_n_to", n_to - base_t, 0);
    check("band_locked", int'(locked), 0);

    // Timeout: one crossing, then constant midline.
    do_reset();
    base_m = n_meas; base_t = n_to;
    put(1'b1, 100);
    put(1'b1, 160);
    for (int i = 0; i < 254; i++) put(1'b1, 128);
    check("to_early", int'(timeout), 0);
    put(1'b1, 128);
    check("to_pulse", int'(timeout), 1);
    check("to_locked", int'(locked), 0);
    idle(2);
    check("to_count", n_to - base_t, 1);
    for (int i = 0; i < 5; i++) put(1'b1, 100);
    for (int i = 0; i < 5; i++) put(1'b1, 160);
    idle(1);
    check("to_no_meas_first", n_meas - base_m, 0);
    for (int i = 0; i < 5; i++) put(1'b1, 100);
    put(1'b1, 160);
    check("to_meas_second", int'(meas_valid), 1);
    check("to_meas_period", int'(period), 10);
    idle(1);

    // Closing crossing at cnt = 254.
    do_reset();
    base_t = n_to;
    put(1'b1, 100);
    put(1'b1, 160);
    put(1'b1, 100);
    for (int i = 0; i < 253; i++) put(1'b1, 128);
    put(1'b1, 160);
    check("edge_meas", int'(meas_valid), 1);
    check("edge_period", int'(period), 255);
    check("edge_timeout", int'(timeout), 0);
    check("edge_amp_max", int'(amp_max), 160);
    check("edge_amp_min", int'(amp_min), 100);
    idle(2);
    check("edge_n_to", n_to - base_t, 0);

    // Asynchronous reset mid-window while locked.
    do_reset();
    square(3);
    for (int i = 0; i < 3; i++) put(1'b1, 100);
    check("ar_locked_before", int'(locked), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_meas_valid", int'(meas_valid), 0);
    check("ar_timeout", int'(timeout), 0);
    check("ar_locked", int'(locked), 0);
    check("ar_period", int'(period), 0);
    check("ar_amp_max", int'(amp_max), 0);
    check("ar_amp_min", int'(amp_min), 0);
    sample_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    base_m = n_meas;
    square(1);
    idle(1);
    check("ar_no_meas_first", n_meas - base_m, 0);
    for (int i = 0; i < 5; i++) put(1'b1, 100);
    put(1'b1, 160);
    check("ar_meas_second", int'(meas_valid), 1);
    check("ar_period_after", int'(period), 10);
    idle(2);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
